// File: rtl/axi_read_gen_chk.sv
// axi_read_gen_chk
//   AXI read master with inline response checking. Commands (addr/len/size/
//   burst plus the header expected in beat 0) are accepted on a valid/ready
//   port and issued on AR. R beats are checked per burst for header, RRESP,
//   RID and RLAST placement, and a per-burst result plus saturating pass/fail
//   counters are reported. Up to MAX_OUT bursts may be outstanding; responses
//   are assumed to return in order on a single ID.
//
// Ports
//   i_clk, i_reset_n          clock, async active-low reset
//   i_clear                   sync clear of pass/fail counters and sticky flag
//   i_cmd_*/o_cmd_ready       command port (valid/ready)
//   ar*                       AXI read-address channel (master side)
//   r*                        AXI read-data channel (master side)
//   o_res_valid/pass/err      one-cycle burst result
//                             err[0] header mismatch, [1] rresp != OKAY,
//                             [2] early rlast, [3] missing rlast / rid mismatch
//   o_pass_cnt/o_fail_cnt     saturating burst counters
//   o_outstanding             bursts issued but not yet completed
//   o_err_sticky              set by any failed burst until clear/reset
module axi_read_gen_chk #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int ID_W     = 7,
    parameter int HDR_W    = 128,
    parameter int ARID_VAL = 0,
    parameter int MAX_OUT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [ADDR_W-1:0]          i_cmd_addr,
    input  logic [7:0]                 i_cmd_len,
    input  logic [2:0]                 i_cmd_size,
    input  logic [1:0]                 i_cmd_burst,
    input  logic [HDR_W-1:0]           i_cmd_hdr,
    output logic [ID_W-1:0]            arid,
    output logic [ADDR_W-1:0]          araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [ID_W-1:0]            rid,
    input  logic [DATA_W-1:0]          rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    output logic                       o_res_valid,
    output logic                       o_res_pass,
    output logic [3:0]                 o_res_err,
    output logic [CNT_W-1:0]           o_pass_cnt,
    output logic [CNT_W-1:0]           o_fail_cnt,
    output logic [$clog2(MAX_OUT):0]   o_outstanding,
    output logic                       o_err_sticky
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int OUT_W = PTR_W + 1;
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  ARID_C    = ID_W'(ARID_VAL);

    // Tracking FIFO: one entry per issued burst, {len, expected header}.
    logic [7:0]       len_mem [MAX_OUT];
    logic [HDR_W-1:0] hdr_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [7:0]       beat_cnt;
    logic [3:0]       err_acc;
    logic [3:0]       err_beat;
    logic [3:0]       err_total;
    logic [7:0]       head_len;
    logic [HDR_W-1:0] head_hdr;
    logic             accept;
    logic             r_beat;
    logic             burst_end;

    assign arid        = ARID_C;
    assign o_cmd_ready = (!arvalid || arready) && (o_outstanding < MAX_OUT_C);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign rready      = (o_outstanding != '0);
    assign r_beat      = rvalid && rready;
    assign head_len    = len_mem[rd_ptr];
    assign head_hdr    = hdr_mem[rd_ptr];

    generate
        if (HDR_W < DATA_W) begin : g_unused_data
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^rdata[DATA_W-1:HDR_W];
        end
    endgenerate

    // Per-beat checks against the FIFO head. A burst ends either on rlast or
    // on the beat where the count reaches len, whichever comes first, so a
    // misbehaving slave cannot desynchronise the following bursts.
    always_comb begin
        err_beat = '0;
        if (beat_cnt == 8'd0 && rdata[HDR_W-1:0] != head_hdr) begin
            err_beat[0] = 1'b1;
        end
        if (rresp != 2'b00) begin
            err_beat[1] = 1'b1;
        end
        if (rid != ARID_C) begin
            err_beat[3] = 1'b1;
        end
        if (rlast && beat_cnt < head_len) begin
            err_beat[2] = 1'b1;
        end
        if (beat_cnt == head_len && !rlast) begin
            err_beat[3] = 1'b1;
        end
        err_total = err_acc | err_beat;
        burst_end = r_beat && (rlast || beat_cnt == head_len);
    end

    // AR channel: payload loads on accept and is held until arready.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arburst <= '0;
        end else if (accept) begin
            arvalid <= 1'b1;
            araddr  <= i_cmd_addr;
            arlen   <= i_cmd_len;
            arsize  <= i_cmd_size;
            arburst <= i_cmd_burst;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            len_mem[wr_ptr] <= i_cmd_len;
            hdr_mem[wr_ptr] <= i_cmd_hdr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_outstanding <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (burst_end) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, burst_end})
                2'b10:   o_outstanding <= o_outstanding + 1'b1;
                2'b01:   o_outstanding <= o_outstanding - 1'b1;
                default: o_outstanding <= o_outstanding;
            endcase
        end
    end

    // Beat counter, error accumulation and result pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            beat_cnt    <= '0;
            err_acc     <= '0;
            o_res_valid <= 1'b0;
            o_res_pass  <= 1'b0;
            o_res_err   <= '0;
        end else begin
            o_res_valid <= burst_end;
            if (burst_end) begin
                beat_cnt   <= '0;
                err_acc    <= '0;
                o_res_err  <= err_total;
                o_res_pass <= (err_total == 4'd0);
            end else if (r_beat) begin
                beat_cnt <= beat_cnt + 8'd1;
                err_acc  <= err_total;
            end
        end
    end

    // Counters move on the same edge that raises o_res_valid; clear wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pass_cnt   <= '0;
            o_fail_cnt   <= '0;
            o_err_sticky <= 1'b0;
        end else if (i_clear) begin
            o_pass_cnt   <= '0;
            o_fail_cnt   <= '0;
            o_err_sticky <= 1'b0;
        end else if (burst_end) begin
            if (err_total == 4'd0) begin
                if (o_pass_cnt != '1) begin
                    o_pass_cnt <= o_pass_cnt + 1'b1;
                end
            end else begin
                o_err_sticky <= 1'b1;
                if (o_fail_cnt != '1) begin
                    o_fail_cnt <= o_fail_cnt + 1'b1;
                end
            end
        end
    end

endmodule
